// File: rtl/wb_pio_host.sv
// wb_pio_host: Wishbone classic single-transfer initiator.
//
// Takes one command (address, data, byte selects, read/write) on a valid/ready
// port and runs a single Wishbone classic cycle. The outcome comes back on a
// valid/ready response port. If no ack arrives within TIMEOUT bus cycles the
// transfer is abandoned, an error response is returned, and a saturating error
// counter is bumped.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   cmd_*                   command channel (valid/ready, we, adr, dat, sel)
//   rsp_*                   response channel (valid/ready, read data, error)
//   wbm_*                   Wishbone master interface (all outputs registered)
//   err_count_o             saturating count of timed-out transfers
module wb_pio_host #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,

    output logic [7:0]  err_count_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBus  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // Counter value on the edge that completes the TIMEOUT-th unacked bus cycle.
    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q,   state_d;
    logic            cyc_q,     cyc_d;
    logic            we_q,      we_d;
    logic [3:0]      sel_q,     sel_d;
    logic [31:0]     adr_q,     adr_d;
    logic [31:0]     dat_q,     dat_d;
    logic [31:0]     rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [TO_W-1:0] to_cnt_q,  to_cnt_d;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        err_cnt_d = err_cnt_q;
        to_cnt_d  = to_cnt_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    state_d  = StBus;
                    cyc_d    = 1'b1;
                    we_d     = cmd_we_i;
                    sel_d    = cmd_sel_i;
                    adr_d    = cmd_adr_i;
                    dat_d    = cmd_dat_i;
                    to_cnt_d = '0;
                end
            end
            StBus: begin
                if (wbm_ack_i || (to_cnt_q == ToLast)) begin
                    // Either way the bus is released and the master signals
                    // return to zero.
                    state_d = StResp;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    // Ack is checked first so an ack on the timeout edge wins.
                    if (wbm_ack_i) begin
                        rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                        rsp_err_d = 1'b0;
                    end else begin
                        rsp_dat_d = 32'h0;
                        rsp_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d   = StIdle;
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            err_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            err_cnt_q <= err_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    // Classic single transfers: strobe and cycle are always asserted together.
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_wb_pio_host.sv
module tb_wb_pio_host;

    localparam int unsigned TIMEOUT = 64;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i, cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [7:0]  err_count_o;

    int passed = 0;
    int total  = 0;
    int model_err = 0;  // reference error counter (saturates at 255)

    wb_pio_host #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .err_count_o (err_count_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // One transfer. ack_cycle: stb cycle (1-based) on which the slave acks, 0 = never.
    // rsp_delay: cycles rsp_ready_i is held low once the response is present.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int ack_cycle, input logic [31:0] rdata,
                       input int rsp_delay);
        int  n;
        bit  done;
        bit  ok;
        int  exp_n;
        logic [31:0] exp_dat;
        ok      = (ack_cycle != 0) && (ack_cycle <= TIMEOUT);
        exp_n   = ok ? ack_cycle : TIMEOUT;
        exp_dat = (ok && !we) ? rdata : 32'h0;
        if (!ok && model_err < 255) model_err++;

        chk("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        tick();
        cmd_valid_i = 1'b0;
        cmd_adr_i   = $urandom;
        cmd_dat_i   = $urandom;
        cmd_we_i    = ~we;
        cmd_sel_i   = ~sel;

        n    = 0;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            chk("bus_cyc", {31'b0, wbm_cyc_o}, 32'd1);
            chk("bus_stb", {31'b0, wbm_stb_o}, 32'd1);
            chk("bus_we", {31'b0, wbm_we_o}, {31'b0, we});
            chk("bus_adr", wbm_adr_o, adr);
            chk("bus_dat", wbm_dat_o, dat);
            chk("bus_sel", {28'b0, wbm_sel_o}, {28'b0, sel});
            chk("bus_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
            n++;
            if (n == ack_cycle) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            tick();
            wbm_ack_i = 1'b0;
            if (!wbm_cyc_o) done = 1;
        end
        chk("stb_cycles", n, exp_n);

        for (int d = 0; d <= rsp_delay; d++) begin
            chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
            chk("rsp_dat", rsp_dat_o, exp_dat);
            chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, !ok});
            chk("err_count", {24'b0, err_count_o}, model_err);
            chk("rsp_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
            chk("rsp_cyc", {31'b0, wbm_cyc_o}, 32'd0);
            chk("rsp_adr", wbm_adr_o, 32'h0);
            if (d < rsp_delay) tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("rsp_done_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rsp_done_ready", {31'b0, cmd_ready_o}, 32'd1);
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_dat_i   = '0;
        wbm_ack_i   = 1'b0;
        #12;
        chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_err_count", {24'b0, err_count_o}, 32'd0);
        wb_rst_i = 1'b0;
        tick();

        // Directed cases.
        txn(1'b1, 32'h761c_0008, 32'hA5A5_1234, 4'hF, 1, 32'hDEAD_BEEF, 0);
        txn(1'b0, 32'h761c_0004, 32'h0, 4'hF, 4, 32'hCAFE_F00D, 0);
        txn(1'b0, 32'h761c_0010, 32'h0, 4'h3, 0, 32'h1234_5678, 0);        // timeout
        txn(1'b0, 32'h761c_0014, 32'h0, 4'hC, TIMEOUT, 32'h0BAD_CAFE, 0);  // ack on last cycle
        txn(1'b1, 32'h761c_0018, 32'h5555_AAAA, 4'h1, 2, 32'hFFFF_FFFF, 10); // backpressure

        // Stray ack while idle must not create a response.
        for (int i = 0; i < 3; i++) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = $urandom;
            tick();
            chk("stray_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
            chk("stray_cyc", {31'b0, wbm_cyc_o}, 32'd0);
            chk("stray_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        end
        wbm_ack_i = 1'b0;

        // Async reset mid-BUS, asserted between clock edges.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h761c_0020;
        cmd_dat_i   = 32'h0F0F_0F0F;
        cmd_sel_i   = 4'hF;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("pre_rst_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        #4 wb_rst_i = 1'b1;
        #1;
        model_err = 0;
        chk("async_rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("async_rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("async_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("async_rst_err_count", {24'b0, err_count_o}, 32'd0);
        chk("async_rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        #1 wb_rst_i = 1'b0;
        tick();
        txn(1'b1, 32'h761c_0020, 32'h0F0F_0F0F, 4'hF, 3, 32'h0, 0);

        // Randomized transfers against the reference model.
        for (int i = 0; i < 24; i++) begin
            int ack;
            ack = $urandom_range(0, 70);
            txn(1'($urandom), 32'h761c_0000 | {16'h0, 16'($urandom) & 16'hFFFC}, $urandom,
                4'($urandom), ack, $urandom, $urandom_range(0, 3));
        end

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            txn(1'b0, 32'h761c_0030, 32'h0, 4'hF, 0, 32'h0, 0);
        end
        chk("err_count_sat", {24'b0, err_count_o}, 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_pio_host.md
Name: wb_pio_host

Overview:
- Wishbone classic single-transfer initiator; the bus-master end of the interface served by the PIO Wishbone slave.
- Accepts one command (address, data, byte selects, read/write) on a valid/ready port and runs one Wishbone cycle.
- Returns read data or error status on a valid/ready response port.
- Used by on-chip sequencers and the testbench harness to drive the PIO register window (0x761c_xxxx) without the management SoC.

Parameters:
- TIMEOUT, 64, bus cycles to wait for wbm_ack_i before abandoning the transfer (1..2^TO_W-1).
- TO_W, 8, width of the timeout counter.

Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  reset, asynchronous, active-high
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  command accepted this cycle when high with cmd_valid_i
- cmd_we_i  input  1  1=write, 0=read
- cmd_adr_i  input  32  byte address
- cmd_dat_i  input  32  write data
- cmd_sel_i  input  4  byte selects
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  response consumed
- rsp_dat_o  output  32  read data (0 for writes and errors)
- rsp_err_o  output  1  transfer timed out
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_sel_o  output  4  Wishbone byte selects
- wbm_adr_o  output  32  Wishbone address
- wbm_dat_o  output  32  Wishbone write data
- wbm_dat_i  input  32  Wishbone read data
- wbm_ack_i  input  1  Wishbone acknowledge
- err_count_o  output  8  saturating count of timed-out transfers

Behaviour:
- Clock and reset: single clock wb_clk_i. Reset wb_rst_i is asynchronous, active-high. Every flop clears immediately on assertion.
- Reset values: all outputs 0, except cmd_ready_o=1 (IDLE). Reset mid-transfer drops wbm_cyc_o/wbm_stb_o at once, discards the pending response and clears err_count_o.
- FSM states: IDLE, BUS, RESP. All Wishbone outputs are registered.
- IDLE:
  - cmd_ready_o=1.
  - On edge with cmd_valid_i=1: latch we/adr/dat/sel, clear timeout counter, go to BUS. wbm_cyc_o=wbm_stb_o=1 from the following cycle.
- BUS:
  - cmd_ready_o=0. cyc, stb, we, sel, adr and dat held stable.
  - Timeout counter increments every BUS cycle without ack.
  - Edge with wbm_ack_i=1: deassert cyc/stb. rsp_dat_o = wbm_dat_i for reads, 0 for writes. rsp_err_o=0. Go to RESP.
  - Edge where counter reaches TIMEOUT with wbm_ack_i=0: deassert cyc/stb, rsp_dat_o=0, rsp_err_o=1, err_count_o += 1 (saturates at 255), go to RESP.
  - Ack on the same edge as timeout: ack wins; no error.
- RESP:
  - rsp_valid_o=1. rsp_dat_o and rsp_err_o stable until the edge with rsp_ready_i=1, then go to IDLE.
  - cmd_ready_o=0; no new command while a response is pending.
- Outside BUS: wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o driven 0. wbm_ack_i ignored (stray ack has no effect).
- Latency:
  - Command accepted at edge N: stb high after edge N.
  - Ack sampled at edge N+k (k≥1): rsp_valid_o high after edge N+k.
  - Minimum command-to-command interval is 3 cycles with zero-wait slave and rsp_ready_i tied high.
- wbm_sel_o passes cmd_sel_i unchanged for reads and writes; read data returned as full 32 bits.

Test Plan:
- Write, single-cycle ack: cmd we=1 adr=0x761c_0008 dat=0xA5A5_1234 sel=0xF -> one cycle with cyc=stb=we=1 and matching adr/dat/sel. Slave acks at first stb cycle -> rsp_valid=1, rsp_dat=0, rsp_err=0, then IDLE.
- Read with 3 wait states: cmd we=0 adr=0x761c_0004 sel=0xF. Slave acks on 4th stb cycle with dat=0xCAFE_F00D -> cyc/stb high exactly 4 cycles, rsp_dat=0xCAFE_F00D, rsp_err=0.
- Timeout: TIMEOUT=64, slave never acks -> cyc/stb high 64 cycles then drop. rsp_err=1, rsp_dat=0, err_count_o=1. Ack on exactly the 64th cycle instead -> rsp_err=0, err_count_o unchanged.
- Response backpressure: rsp_ready_i=0 for 10 cycles after completion -> rsp_valid, rsp_dat and rsp_err stable, cmd_ready_o=0, no new cyc. Raise rsp_ready_i -> cmd_ready_o=1 next cycle.
- Async reset mid-transfer: assert wb_rst_i halfway between edges during BUS -> cyc/stb/rsp_valid fall before the next edge. After release, the same command reissues cleanly; stray wbm_ack_i in IDLE produces no response.
- err_count saturation: 260 timed-out reads -> err_count_o=255 and holds.
